bike_orient_write_arbiter: RTL
==============================

Name: bike_orient_write_arbiter

Overview:
- Shares the register file's single write port between CPU writeback and the four player orientation input controllers.
- CPU writeback passes through combinationally and always wins the port.
- Player turn requests are buffered per bike, checked for illegal 180° reversals, and issued round-robin into idle write slots.
- Sits between the writeback stage and the register-file wrapper, driving its ren_in/rd_in/data_write.

Parameters:
- BIKE0_ORIENT_REG, 5'd2, register index holding bike one orientation
- BIKE1_ORIENT_REG, 5'd4, register index holding bike two orientation
- BIKE2_ORIENT_REG, 5'd6, register index holding bike three orientation
- BIKE3_ORIENT_REG, 5'd8, register index holding bike four orientation
- INIT_ORIENT, 8'b00_10_11_01, reset orientation per bike, packed {b3,b2,b1,b0}; encoding 0=up, 1=right, 2=down, 3=left
- STARVE_LIMIT, 8, wait cycles before cpu_hold is raised

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cpu_ren  in  1  CPU writeback enable
- cpu_rd  in  5  CPU writeback destination
- cpu_data  in  32  CPU writeback data
- masterSwitch  in  1  game run enable; 0 = paused
- orient_req  in  4  one-cycle turn request per bike
- orient_val  in  8  requested orientation per bike, packed {b3,b2,b1,b0}
- ren_out  out  1  write enable to register file
- rd_out  out  5  write destination to register file
- data_out  out  32  write data to register file
- cpu_hold  out  1  registered; asks CPU to leave the next write slot empty
- reject  out  4  registered; one-cycle pulse per bike when a request is rejected
- cur_orient  out  8  shadow orientation per bike, packed

Behaviour:
- CPU slot: cpu_busy = cpu_ren & (cpu_rd != 0). When cpu_busy=1, ren_out/rd_out/data_out equal the cpu_* inputs combinationally, with zero added latency.
- Player slot: when cpu_busy=0, masterSwitch=1 and any pending bit is set, grant one bike. Then ren_out=1, rd_out=BIKEk_ORIENT_REG, data_out={30'b0, pend_val[k]}. Otherwise ren_out=0, rd_out=0, data_out=0.
- Round-robin: search starts at rr_ptr+1 (mod 4). rr_ptr updates to the granted index. Reset value is 3, so bike 0 wins first.
- Grant takes effect at the next rising edge: pending[k] clears, shadow[k] takes pend_val[k], rr_ptr advances.
- Request latch, per bike k, at the rising edge where orient_req[k]=1:
  - Effective current orientation = pend_val[k] if pending[k] (and not granted this cycle), else shadow[k].
  - If orient_val[k] == effective ^ 2'b10 (reversal) or == effective (no change), drop the request and pulse reject[k] for the next cycle.
  - Otherwise set pending[k] and load pend_val[k]; the newest request overwrites an older pending one.
- Request arriving in the same cycle bike k is granted: check it against the value being granted, and re-arm pending[k] if it passes.
- CPU snoop: a CPU write with cpu_rd == BIKEk_ORIENT_REG loads shadow[k] from cpu_data[1:0] and clears pending[k]. A player request in that same cycle is checked against cpu_data[1:0].
- masterSwitch=0: no player grants. Requests are still latched and checked. Starvation counter is held.
- Starvation counter:
  - Increments each cycle where any pending bit is set, masterSwitch=1 and cpu_busy=1.
  - Clears on any player grant or when nothing is pending.
  - When it reaches STARVE_LIMIT-1, cpu_hold=1 for the next cycle.
  - CPU contract: it inserts no write while cpu_hold=1. If it writes anyway, the CPU still wins and the counter saturates.
- Latency: request at edge N is pending after N and written in cycle N+1 at the earliest; the regfile captures it on the falling edge of that cycle.
- Reset values: pending=0, pend_val=0, shadow=INIT_ORIENT, rr_ptr=3, starve counter=0, cpu_hold=0, reject=0, cur_orient=INIT_ORIENT. Combinational write outputs follow their rules with pending=0.
- Reset mid-operation discards all pending requests; nothing is written in the following cycle unless the CPU writes.

Test Plan:
1. After reset, pulse orient_req=4'b0001 with b0=2'b00 (up; shadow is right) and CPU idle → next cycle ren_out=1, rd_out=2, data_out=0; then cur_orient[1:0]=0.
2. Pulse orient_req=4'b1111, values {up,down,right,left} (none reversing or repeating), CPU idle → writes to regs 2, 4, 6, 8 on four consecutive cycles; rr_ptr ends at 3.
3. Bike0 shadow=right, request left (3) → no write; reject=4'b0001 for exactly one cycle; cur_orient unchanged.
4. Hold cpu_ren=1, cpu_rd=10 with bike1 pending → CPU writes pass through; cpu_hold=1 after 8 busy cycles; drop cpu_ren → bike1 write to reg 4 in that slot.
5. CPU writes reg 2 data=3 in the same cycle bike0 requests down (2) → shadow0=3; down accepted; pending write reg 2 data=2 follows.
6. masterSwitch=0 with bike2 pending → no writes for 10 cycles; masterSwitch=1 → write reg 6 the next idle cycle. Assert reset with all bikes pending → no player writes afterward.

Source files
------------

// File: rtl/bike_orient_write_arbiter.sv
// Register-file write-port arbiter: CPU writeback passes straight through, while
// buffered player turn requests are legality-checked and issued round-robin into idle slots.
module bike_orient_write_arbiter #(
   parameter logic [4:0]  BIKE0_ORIENT_REG = 5'd2,
   parameter logic [4:0]  BIKE1_ORIENT_REG = 5'd4,
   parameter logic [4:0]  BIKE2_ORIENT_REG = 5'd6,
   parameter logic [4:0]  BIKE3_ORIENT_REG = 5'd8,
   parameter logic [7:0]  INIT_ORIENT      = 8'b00_10_11_01,
   parameter int unsigned STARVE_LIMIT     = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_ren,
   input  logic [4:0]  cpu_rd,
   input  logic [31:0] cpu_data,
   input  logic        masterSwitch,
   input  logic [3:0]  orient_req,
   input  logic [7:0]  orient_val,
   output logic        ren_out,
   output logic [4:0]  rd_out,
   output logic [31:0] data_out,
   output logic        cpu_hold,
   output logic [3:0]  reject,
   output logic [7:0]  cur_orient
);

   localparam int unsigned     CNT_W   = $clog2(STARVE_LIMIT) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);
   localparam logic [3:0][4:0] BIKE_REG = {BIKE3_ORIENT_REG, BIKE2_ORIENT_REG,
                                           BIKE1_ORIENT_REG, BIKE0_ORIENT_REG};

   logic [3:0]       pending, pending_n;
   logic [3:0][1:0]  pend_val, pend_val_n;
   logic [3:0][1:0]  shadow, shadow_n;
   logic [3:0][1:0]  req_val;
   logic [3:0][1:0]  eff;
   logic [3:0]       snoop;
   logic [3:0]       reject_n;
   logic [1:0]       rr_ptr, rr_ptr_n;
   logic [1:0]       grant_idx, cand;
   logic             grant_any;
   logic             cpu_busy;
   logic             any_pend;
   logic             cpu_hold_n;
   logic [CNT_W-1:0] starve_cnt, starve_cnt_n;

   assign cpu_busy   = cpu_ren & (cpu_rd != 5'd0);
   assign any_pend   = |pending;
   assign req_val    = orient_val;
   assign cur_orient = shadow;

   // Round-robin search begins one past the last granted bike.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (!cpu_busy && masterSwitch) begin
         for (int unsigned i = 0; i < 4; i++) begin
            cand = rr_ptr + 2'(i + 1);
            if (!grant_any && pending[cand]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
      end
   end

   always_comb begin
      ren_out  = 1'b0;
      rd_out   = '0;
      data_out = '0;
      if (cpu_busy) begin
         ren_out  = 1'b1;
         rd_out   = cpu_rd;
         data_out = cpu_data;
      end else if (grant_any) begin
         ren_out  = 1'b1;
         rd_out   = BIKE_REG[grant_idx];
         data_out = {30'b0, pend_val[grant_idx]};
      end
   end

   // A new request is judged against whatever the orientation will be after this edge.
   always_comb begin
      pending_n  = pending;
      pend_val_n = pend_val;
      shadow_n   = shadow;
      reject_n   = '0;
      snoop      = '0;
      eff        = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         snoop[k] = cpu_busy && (cpu_rd == BIKE_REG[k]);
         if (snoop[k]) begin
            shadow_n[k]  = cpu_data[1:0];
            pending_n[k] = 1'b0;
            eff[k]       = cpu_data[1:0];
         end else begin
            eff[k] = pending[k] ? pend_val[k] : shadow[k];
            if (grant_any && (grant_idx == 2'(k))) begin
               shadow_n[k]  = pend_val[k];
               pending_n[k] = 1'b0;
            end
         end
         if (orient_req[k]) begin
            if ((req_val[k] == eff[k]) || (req_val[k] == (eff[k] ^ 2'b10))) begin
               reject_n[k] = 1'b1;
            end else begin
               pending_n[k]  = 1'b1;
               pend_val_n[k] = req_val[k];
            end
         end
      end
   end

   always_comb begin
      rr_ptr_n     = grant_any ? grant_idx : rr_ptr;
      starve_cnt_n = starve_cnt;
      if (!any_pend || grant_any) begin
         starve_cnt_n = '0;
      end else if (masterSwitch && cpu_busy && (starve_cnt != CNT_MAX)) begin
         starve_cnt_n = starve_cnt + CNT_W'(1);
      end
      cpu_hold_n = (starve_cnt == CNT_MAX) && any_pend && masterSwitch && !grant_any;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pending    <= '0;
         pend_val   <= '0;
         shadow     <= INIT_ORIENT;
         rr_ptr     <= 2'd3;
         starve_cnt <= '0;
         cpu_hold   <= 1'b0;
         reject     <= '0;
      end else begin
         pending    <= pending_n;
         pend_val   <= pend_val_n;
         shadow     <= shadow_n;
         rr_ptr     <= rr_ptr_n;
         starve_cnt <= starve_cnt_n;
         cpu_hold   <= cpu_hold_n;
         reject     <= reject_n;
      end
   end

endmodule
